// File: rtl/reg_map_params_pkg.sv
// Purpose : shared constants and types for the register map and its EIM host bridge.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: EIM bridge FSM state enum, synchronizer depth, default read error
// pattern, default top register address and an address range helper.
package reg_map_params_pkg;

    // Depth of the strobe synchronizers in the EIM bridge.
    localparam int EIM_SYNC_STAGES = 2;

    // Value returned to the host when a register read never completes.
    localparam logic [15:0] EIM_RD_ERR_DATA = 16'hDEAD;

    // Highest register address decoded by the register map.
    localparam logic [15:0] EIM_ADDR_MAX = 16'h01FF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_DRIVE = 3'd5,
        ST_END      = 3'd6
    } eim_bridge_state_t;

    function automatic logic addr_in_range(input logic [15:0] addr, input logic [15:0] addr_max);
        return addr <= addr_max;
    endfunction

endpackage

// File: rtl/eim_sync2.sv
// Purpose : multi-flop synchronizer for one asynchronous active-low bus strobe.
// Latency : EIM_SYNC_STAGES eim_clk cycles from pin change to q.
// Backpressure: none; free-running sampler.
//
// Ports: eim_clk / eim_rst (async active-high), d = raw pin, q = synchronized pin.
// Resets to 1 so an idle (deasserted) strobe is seen during and after reset.
module eim_sync2
    import reg_map_params_pkg::*;
(
    input  logic eim_clk,
    input  logic eim_rst,
    input  logic d,
    output logic q
);

    logic [EIM_SYNC_STAGES-1:0] sync_sh;

    always_ff @(posedge eim_clk or posedge eim_rst) begin
        if (eim_rst) begin
            sync_sh <= '1;
        end else begin
            sync_sh <= {sync_sh[EIM_SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_sh[EIM_SYNC_STAGES-1];

endmodule

// File: rtl/eim_reg_bridge.sv
// Purpose : EIM muxed AD bus slave -> single-cycle register map write/read requests.
// Latency : ~3 eim_clk from a strobe pin edge to the request; read data driven the cycle after read_data_en.
// Backpressure: RD_WAIT holds the bus read until read_data_en (or timeout when EIM_RD_TIMEOUT_EN is defined).
//
// Ports:
//   eim_clk, eim_rst                         clock / async active-high reset
//   eim_cs_n, eim_adv_n, eim_we_n, eim_oe_n  raw async host strobes (active low)
//   eim_ad_in / eim_ad_out / eim_ad_oe       muxed AD bus in, read data out, tristate enable
//   reg_addr, reg_data                       address / write data to the register map
//   reg_data_index, reg_read_index           one-cycle write strobe / read request
//   reg_read_out, read_data_en               read data and its valid from the register map
//   rd_timeout                               sticky read timeout flag
// Optional feature macro: EIM_RD_TIMEOUT_EN (read timeout counter and rd_timeout flag).
module eim_reg_bridge
    import reg_map_params_pkg::*;
#(
    parameter logic [15:0] ADDR_MAX    = EIM_ADDR_MAX,
    parameter int          RD_TIMEOUT  = 16,
    parameter logic [15:0] RD_ERR_DATA = EIM_RD_ERR_DATA
) (
    input  logic        eim_clk,
    input  logic        eim_rst,
    input  logic        eim_cs_n,
    input  logic        eim_adv_n,
    input  logic        eim_we_n,
    input  logic        eim_oe_n,
    input  logic [15:0] eim_ad_in,
    output logic [15:0] eim_ad_out,
    output logic        eim_ad_oe,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_data,
    output logic        reg_data_index,
    output logic        reg_read_index,
    input  logic [15:0] reg_read_out,
    input  logic        read_data_en,
    output logic        rd_timeout
);

    logic cs_s, adv_s, we_s, oe_s;
    logic we_q;       // previous synced we, for rising-edge detection
    logic drive_q;    // FSM permission to drive the AD bus
    eim_bridge_state_t state;

    eim_sync2 u_sync_cs  (.eim_clk(eim_clk), .eim_rst(eim_rst), .d(eim_cs_n),  .q(cs_s));
    eim_sync2 u_sync_adv (.eim_clk(eim_clk), .eim_rst(eim_rst), .d(eim_adv_n), .q(adv_s));
    eim_sync2 u_sync_we  (.eim_clk(eim_clk), .eim_rst(eim_rst), .d(eim_we_n),  .q(we_s));
    eim_sync2 u_sync_oe  (.eim_clk(eim_clk), .eim_rst(eim_rst), .d(eim_oe_n),  .q(oe_s));

    // Gated with the raw pins so the bus is released as soon as the host
    // deasserts oe or cs, without waiting for the synchronizers.
    assign eim_ad_oe = drive_q & ~eim_oe_n & ~eim_cs_n;

`ifdef EIM_RD_TIMEOUT_EN
    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
    logic [CNT_W-1:0] tmo_cnt;
`else
    // Keeps the timeout parameters referenced when the feature is compiled out.
    logic unused_cfg;
    assign unused_cfg = (^RD_ERR_DATA) ^ (RD_TIMEOUT != 0);
    assign rd_timeout = 1'b0;
`endif

    always_ff @(posedge eim_clk or posedge eim_rst) begin
        if (eim_rst) begin
            state          <= ST_IDLE;
            reg_addr       <= '0;
            reg_data       <= '0;
            reg_data_index <= 1'b0;
            reg_read_index <= 1'b0;
            eim_ad_out     <= '0;
            drive_q        <= 1'b0;
            we_q           <= 1'b1;
`ifdef EIM_RD_TIMEOUT_EN
            tmo_cnt        <= '0;
            rd_timeout     <= 1'b0;
`endif
        end else begin
            reg_data_index <= 1'b0;
            reg_read_index <= 1'b0;
            we_q           <= we_s;

            // Host ending the cycle early cancels whatever is in flight.
            if (state != ST_IDLE && cs_s) begin
                state   <= ST_IDLE;
                drive_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!cs_s && !adv_s) state <= ST_ADDR;
                    end
                    ST_ADDR: begin
                        if (!adv_s) begin
                            reg_addr <= eim_ad_in;
                        end else if (!we_s) begin
                            state <= ST_WR_WAIT;   // write wins if oe is also low
                        end else if (!oe_s) begin
                            state <= ST_RD_REQ;
                        end
                    end
                    ST_WR_WAIT: begin
                        if (!we_s) reg_data <= eim_ad_in;
                        if (we_s && !we_q) begin
                            reg_data_index <= addr_in_range(reg_addr, ADDR_MAX);
                            state          <= ST_END;
                        end
                    end
                    ST_RD_REQ: begin
`ifdef EIM_RD_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (addr_in_range(reg_addr, ADDR_MAX)) begin
                            reg_read_index <= 1'b1;
                            state          <= ST_RD_WAIT;
                        end else begin
                            eim_ad_out <= '0;
                            drive_q    <= 1'b1;
                            state      <= ST_RD_DRIVE;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (read_data_en) begin
                            eim_ad_out <= reg_read_out;
                            drive_q    <= 1'b1;
                            state      <= ST_RD_DRIVE;
`ifdef EIM_RD_TIMEOUT_EN
                        end else if (tmo_cnt == CNT_LAST) begin
                            eim_ad_out <= RD_ERR_DATA;
                            rd_timeout <= 1'b1;
                            drive_q    <= 1'b1;
                            state      <= ST_RD_DRIVE;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
`endif
                        end
                    end
                    ST_RD_DRIVE: begin
                        if (oe_s) begin
                            drive_q <= 1'b0;
                            state   <= ST_END;
                        end
                    end
                    ST_END: begin
                        if (cs_s) state <= ST_IDLE;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        drive_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
